// File: rtl/switch_state_ctrl.sv
// Per-step switch state controller: samples gate and switch current on sta, decides ON/OFF
// with current-zero turn-off and a minimum-dwell hold-off, then launches the chooser.
module switch_state_ctrl #(
   parameter int DATA_W    = 64,
   parameter int MIN_DWELL = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sta,
   input  logic              gate,
   input  logic [DATA_W-1:0] i_sw,
   output logic              beta_flag,
   output logic              event_flag,
   output logic              sta_out,
   output logic              done_sig,
   output logic              busy,
   output logic              overrun,
   output logic              nan_err
);

   localparam int DWELL_W = (MIN_DWELL < 1) ? 1 : $clog2(MIN_DWELL + 1);
   localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(MIN_DWELL);

   typedef enum logic [1:0] {S_IDLE, S_CAPT, S_EVAL} state_t;

   state_t               state, state_nx;
   logic                 gate_p0;
   logic [DATA_W-1:0]    i_sw_p0;
   logic [DWELL_W-1:0]   dwell, dwell_nx;
   logic                 cap_en;
   logic                 beta_nx, event_nx, pulse_nx, busy_nx, overrun_nx, nan_nx;
   logic                 pulse_r;
   logic                 nan_c, nonpos_c, allow_c, change_c;

   function automatic logic fp_is_zero(input logic [DATA_W-1:0] w);
      return (w[62:52] == 11'd0);
   endfunction

   function automatic logic fp_is_nan(input logic [DATA_W-1:0] w);
      return (w[62:52] == 11'h7FF) && (w[51:0] != 52'd0);
   endfunction

   function automatic logic fp_is_nonpos(input logic [DATA_W-1:0] w);
      return w[63] | fp_is_zero(w);
   endfunction

   function automatic logic [DWELL_W-1:0] dwell_sat_inc(input logic [DWELL_W-1:0] d);
      return (d >= DWELL_MAX) ? DWELL_MAX : d + 1'b1;
   endfunction

   // Capture stage: data is only meaningful while the FSM is mid-step, so it carries no reset
   always_ff @(posedge clk) begin
      if (cap_en) begin
         gate_p0 <= gate;
         i_sw_p0 <= i_sw;
      end
   end

   assign nan_c    = fp_is_nan(i_sw_p0);
   assign nonpos_c = fp_is_nonpos(i_sw_p0);
   assign allow_c  = (dwell >= DWELL_MAX);
   assign change_c = !nan_c && allow_c &&
                     (beta_flag ? (!gate_p0 && nonpos_c) : gate_p0);

   // CAPT holds the sampled step and evaluates on its exit edge; EVAL publishes the result
   always_comb begin
      state_nx   = state;
      cap_en     = 1'b0;
      beta_nx    = beta_flag;
      event_nx   = 1'b0;
      pulse_nx   = 1'b0;
      busy_nx    = busy;
      overrun_nx = overrun;
      nan_nx     = nan_err;
      dwell_nx   = dwell;
      case (state)
         S_IDLE: begin
            if (sta) begin
               cap_en   = 1'b1;
               busy_nx  = 1'b1;
               state_nx = S_CAPT;
            end
         end
         S_CAPT: begin
            if (sta) overrun_nx = 1'b1;
            if (nan_c) nan_nx = 1'b1;
            if (change_c) begin
               beta_nx  = ~beta_flag;
               event_nx = 1'b1;
               dwell_nx = '0;
            end else begin
               dwell_nx = dwell_sat_inc(dwell);
            end
            state_nx = S_EVAL;
         end
         S_EVAL: begin
            if (sta) overrun_nx = 1'b1;
            pulse_nx = 1'b1;
            busy_nx  = 1'b0;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         beta_flag  <= 1'b0;
         event_flag <= 1'b0;
         pulse_r    <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
         nan_err    <= 1'b0;
         dwell      <= DWELL_MAX;
      end else begin
         state      <= state_nx;
         beta_flag  <= beta_nx;
         event_flag <= event_nx;
         pulse_r    <= pulse_nx;
         busy       <= busy_nx;
         overrun    <= overrun_nx;
         nan_err    <= nan_nx;
         dwell      <= dwell_nx;
      end
   end

   assign sta_out  = pulse_r;
   assign done_sig = pulse_r;

endmodule

// File: tb/tb_switch_state_ctrl.sv
// Self-checking bench for switch_state_ctrl: directed scenarios plus randomized steps
// compared against a step-level behavioural model.
module tb_switch_state_ctrl;

   localparam int MIN_DWELL = 2;
   localparam logic [63:0] P_ONE  = 64'h3FF0000000000000;
   localparam logic [63:0] N_ONE  = 64'hBFF0000000000000;
   localparam logic [63:0] N_ZERO = 64'h8000000000000000;
   localparam logic [63:0] DENORM = 64'h0000000000000001;
   localparam logic [63:0] QNAN   = 64'h7FF8000000000000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sta = 1'b0;
   logic        gate = 1'b0;
   logic [63:0] i_sw = 64'd0;
   logic        beta_flag, event_flag, sta_out, done_sig, busy, overrun, nan_err;

   int checks = 0;
   int failures = 0;

   // model state
   bit m_beta;
   int m_since;
   bit m_ovr;
   bit m_nan;

   switch_state_ctrl #(.DATA_W(64), .MIN_DWELL(MIN_DWELL)) dut (
      .clk(clk), .rst(rst), .sta(sta), .gate(gate), .i_sw(i_sw),
      .beta_flag(beta_flag), .event_flag(event_flag), .sta_out(sta_out),
      .done_sig(done_sig), .busy(busy), .overrun(overrun), .nan_err(nan_err)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] outs();
      return {beta_flag, event_flag, sta_out, done_sig, busy, overrun, nan_err};
   endfunction

   function automatic logic [63:0] pick_isw();
      case ($urandom_range(0, 8))
         0: return P_ONE;
         1: return N_ONE;
         2: return 64'd0;
         3: return N_ZERO;
         4: return DENORM;
         5: return 64'h7FF0000000000000;
         6: return 64'hFFF0000000000000;
         7: return QNAN;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic model_reset();
      m_beta = 1'b0; m_since = MIN_DWELL; m_ovr = 1'b0; m_nan = 1'b0;
   endtask

   task automatic apply_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1; sta = 1'b0;
      repeat (cycles) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // One full step; expectations come from the model applied to the step's rules.
   task automatic run_step(input bit g, input logic [63:0] x, input string name);
      logic [6:0] exp_v;
      logic [10:0] ex;
      bit is_nan, nonpos, allowed, chg, old_beta, old_nan;
      ex      = x[62:52];
      is_nan  = (ex == 11'h7FF) && (x[51:0] != 52'd0);
      nonpos  = x[63] || (ex == 11'd0);
      allowed = (m_since >= MIN_DWELL);
      chg     = !is_nan && allowed && (m_beta ? (!g && nonpos) : g);
      old_beta = m_beta;
      old_nan  = m_nan;
      @(negedge clk);
      sta = 1'b1; gate = g; i_sw = x;
      @(negedge clk);
      sta = 1'b0; gate = $urandom_range(0, 1); i_sw = {$urandom, $urandom};
      exp_v = {old_beta, 1'b0, 1'b0, 1'b0, 1'b1, m_ovr, old_nan};
      checks++;
      if (outs() !== exp_v) begin
         failures++;
         $display("FAIL %s capt: got %b want %b", name, outs(), exp_v);
      end
      if (chg) begin m_beta = !m_beta; m_since = 0; end
      else if (m_since < 1000) m_since++;
      if (is_nan) m_nan = 1'b1;
      @(negedge clk);
      exp_v = {m_beta, chg, 1'b0, 1'b0, 1'b1, m_ovr, m_nan};
      checks++;
      if (outs() !== exp_v) begin
         failures++;
         $display("FAIL %s eval: got %b want %b", name, outs(), exp_v);
      end
      @(negedge clk);
      exp_v = {m_beta, 1'b0, 1'b1, 1'b1, 1'b0, m_ovr, m_nan};
      checks++;
      if (outs() !== exp_v) begin
         failures++;
         $display("FAIL %s done: got %b want %b", name, outs(), exp_v);
      end
   endtask

   task automatic test_reset();
      apply_reset(2);
      checks++;
      if (outs() !== 7'b0) begin
         failures++;
         $display("FAIL reset: got %b want %b", outs(), 7'b0);
      end
   endtask

   task automatic test_turn_on();
      test_reset();
      run_step(1'b1, P_ONE, "turn_on");
      checks++;
      if (beta_flag !== 1'b1) begin
         failures++;
         $display("FAIL turn_on_beta: got %b want 1", beta_flag);
      end
   endtask

   task automatic test_zero_crossing();
      logic [63:0] offs[3];
      offs[0] = N_ONE; offs[1] = N_ZERO; offs[2] = DENORM;
      test_reset();
      for (int k = 0; k < 3; k++) begin
         run_step(1'b0, P_ONE, "zc_settle_off");
         run_step(1'b0, P_ONE, "zc_settle_off");
         run_step(1'b1, P_ONE, "zc_on");
         run_step(1'b0, P_ONE, "zc_hold_pos");
         run_step(1'b0, P_ONE, "zc_hold_pos");
         run_step(1'b0, P_ONE, "zc_still_pos");
         checks++;
         if (beta_flag !== 1'b1) begin
            failures++;
            $display("FAIL zc_pos_hold: got %b want 1", beta_flag);
         end
         run_step(1'b0, offs[k], "zc_off");
         checks++;
         if (beta_flag !== 1'b0) begin
            failures++;
            $display("FAIL zc_off_%0d: got %b want 0", k, beta_flag);
         end
      end
   endtask

   task automatic test_dwell();
      test_reset();
      run_step(1'b1, P_ONE, "dwell_on");
      run_step(1'b0, N_ONE, "dwell_n1");
      run_step(1'b0, N_ONE, "dwell_n2");
      checks++;
      if (beta_flag !== 1'b1) begin
         failures++;
         $display("FAIL dwell_hold: got %b want 1", beta_flag);
      end
      run_step(1'b0, N_ONE, "dwell_n3");
      checks++;
      if (beta_flag !== 1'b0) begin
         failures++;
         $display("FAIL dwell_release: got %b want 0", beta_flag);
      end
   endtask

   task automatic test_nan();
      test_reset();
      run_step(1'b1, QNAN, "nan_gate1");
      run_step(1'b1, P_ONE, "nan_turn_on");
      run_step(1'b0, N_ONE, "nan_wait");
      run_step(1'b0, N_ONE, "nan_wait");
      run_step(1'b0, QNAN, "nan_gate0");
      checks++;
      if ({beta_flag, nan_err} !== 2'b11) begin
         failures++;
         $display("FAIL nan_sticky: got %b want 11", {beta_flag, nan_err});
      end
      test_reset();
   endtask

   task automatic test_overrun();
      int pulses;
      test_reset();
      @(negedge clk);
      sta = 1'b1; gate = 1'b1; i_sw = P_ONE;
      @(negedge clk);
      gate = 1'b0; i_sw = N_ONE;
      @(negedge clk);
      sta = 1'b0;
      checks++;
      if ({beta_flag, event_flag, busy, overrun} !== 4'b1111) begin
         failures++;
         $display("FAIL overrun_eval: got %b want 1111", {beta_flag, event_flag, busy, overrun});
      end
      pulses = 0;
      repeat (4) begin
         @(negedge clk);
         if (sta_out) pulses++;
      end
      checks++;
      if (pulses != 1 || overrun !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL overrun_pulse: got pulses=%0d ovr=%b busy=%b want pulses=1 ovr=1 busy=0",
                  pulses, overrun, busy);
      end
      m_beta = 1'b1; m_since = 1; m_ovr = 1'b1;
      run_step(1'b0, N_ONE, "overrun_after");
   endtask

   task automatic test_reset_mid_step();
      int pulses;
      test_reset();
      @(negedge clk);
      sta = 1'b1; gate = 1'b1; i_sw = P_ONE;
      @(negedge clk);
      sta = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (sta_out || done_sig || busy || beta_flag) pulses++;
      end
      checks++;
      if (pulses != 0 || outs() !== 7'b0) begin
         failures++;
         $display("FAIL rst_mid_step: got activity=%0d outs=%b want 0 and 0000000", pulses, outs());
      end
      // sta coincident with rst must not start a step
      @(negedge clk);
      rst = 1'b1; sta = 1'b1; gate = 1'b1; i_sw = P_ONE;
      @(negedge clk);
      rst = 1'b0; sta = 1'b0;
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (sta_out || busy || beta_flag) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         failures++;
         $display("FAIL rst_with_sta: got activity=%0d want 0", pulses);
      end
      model_reset();
   endtask

   task automatic test_random();
      test_reset();
      for (int n = 0; n < 60; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_step(1'($urandom_range(0, 1)), pick_isw(), "random");
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_turn_on();
      test_zero_crossing();
      test_dwell();
      test_nan();
      test_overrun();
      test_reset_mid_step();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/switch_state_ctrl.md
Name: switch_state_ctrl

Overview:
- Per-time-step switch state controller for the real-time network solver.
- Sits directly upstream of the 64-bit chooser switch and produces the `beta_flag` that selects between its two 64-bit admittance/history inputs, plus the start pulse that launches it.
- On each solver step it samples the gate command and the IEEE-754 double switch current, then decides ON/OFF with thyristor-style turn-off at current zero crossing and a minimum-dwell hold-off.

Parameters:
- DATA_W, 64, width of switch-current word (IEEE-754 double; only 64 supported)
- MIN_DWELL, 2, minimum solver steps between consecutive state changes (0 = no hold-off)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sta  input  1  step-start pulse, one cycle
- gate  input  1  firing command, sampled with sta
- i_sw  input  DATA_W  switch current, IEEE-754 double, sampled with sta
- beta_flag  output  1  0 = OFF (chooser takes datain1), 1 = ON (chooser takes datain2)
- event_flag  output  1  one-cycle pulse when beta_flag changes this step
- sta_out  output  1  one-cycle start pulse to chooser
- done_sig  output  1  one-cycle step-complete pulse, coincident with sta_out
- busy  output  1  step in progress
- overrun  output  1  sticky: sta received while busy
- nan_err  output  1  sticky: NaN current sampled

Behaviour:
- Reset (synchronous, rst=1 at a rising edge) values:
  - all outputs 0; beta state OFF; dwell counter = MIN_DWELL (saturated); step FSM IDLE.
  - Reset overrides everything, including mid-step: pending pulses are dropped and the captured data is discarded.
- Step FSM: IDLE -> CAPT -> EVAL -> IDLE.
  - Edge T, with sta=1 in IDLE: register gate and i_sw; busy=1; go CAPT.
  - Edge T+1 (EVAL): compute the decision; update beta_flag and event_flag.
  - Edge T+2: sta_out=1 and done_sig=1 for exactly one cycle; busy=0; back to IDLE.
  - Latency sta -> sta_out is 2 cycles. beta_flag is stable one cycle before sta_out and holds until the next step's EVAL.
- sta while busy: ignored (no capture, no restart); overrun set, sticky until rst.
- Current classification, from the captured word:
  - zero = exponent bits [62:52] == 0. Denormals and ±0 count as zero.
  - nan = exponent == 11'h7FF and mantissa != 0.
  - nonpos = sign bit | zero. ±Inf are classified by sign only.
- Beta state transitions, evaluated in EVAL:
  - OFF -> ON when gate=1 and dwell >= MIN_DWELL.
  - ON -> OFF when gate=0 and nonpos=1 and dwell >= MIN_DWELL.
  - nan=1: no transition; nan_err set (sticky).
  - All other cases hold the state.
- Dwell counter:
  - on a transition: cleared to 0;
  - otherwise: +1 per completed step, saturating at MIN_DWELL.
  - Width is clog2(MIN_DWELL+1), minimum 1 bit. MIN_DWELL=0 means transitions are always allowed.
- event_flag: 1 for the single cycle after EVAL when the state changed, else 0.
- sta and rst on the same edge: rst wins; the step is not started.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset then idle: rst high 2 cycles -> all outputs 0. Then sta with gate=1, i_sw=64'h3FF0000000000000 (+1.0) -> beta_flag=1 and event_flag=1 one cycle after sta; sta_out and done_sig pulse 2 cycles after sta.
- Turn-off waits for zero crossing (MIN_DWELL=2, starting ON, dwell saturated):
  - gate=0, i_sw=+1.0 -> beta stays 1.
  - next step, i_sw=64'hBFF0000000000000 (-1.0) -> beta=0 with event_flag pulse.
  - repeat with i_sw=64'h8000000000000000 (-0.0) and with 64'h0000000000000001 (denormal) -> both turn off.
- Dwell hold-off: turn ON at step n; step n+1 with gate=0, i_sw=-1.0 -> stays ON (dwell=0); step n+2 -> stays ON (dwell=1); step n+3 -> OFF.
- NaN: i_sw=64'h7FF8000000000000 with gate toggled -> no state change, no event_flag, nan_err=1 and persists until rst.
- Overrun: sta at T and T+1 -> single sta_out at T+2, overrun=1. Second case: rst asserted at T+1 -> no sta_out or done_sig, beta OFF, busy=0.
